// File: rtl/line_mem.sv
// Line-granular memory with a fixed access latency and a single outstanding request.
// Optional LINE_MEM_BOUNDS_CHECK_EN rejects out-of-range line indices and pulses err.
module line_mem #(
  parameter int unsigned LINE_SIZE = 16,
  parameter int unsigned DEPTH     = 16384,
  parameter int unsigned LATENCY   = 50
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   is_input_valid,
  input  logic [31:0]            addr,
  input  logic                   mem_read,
  input  logic                   mem_write,
  input  logic [LINE_SIZE*8-1:0] din,
  output logic                   is_output_valid,
  output logic [LINE_SIZE*8-1:0] dout,
  output logic                   mem_ready
`ifdef LINE_MEM_BOUNDS_CHECK_EN
  ,
  output logic                   err
`endif
);

  localparam int unsigned LW  = LINE_SIZE * 8;
  localparam int unsigned OFF = $clog2(LINE_SIZE / 4);
  localparam int unsigned IW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW  = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  typedef enum logic [1:0] {StIdle, StBusy, StResp} state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [IW-1:0]   idx_q;
  logic            write_q;
  logic [LW-1:0]   din_q;
  logic            valid_q, valid_d;
  logic [LW-1:0]   dout_q;
  logic            latch_req;
  logic            mem_we;
  logic            dout_load;
  logic [IW-1:0]   req_idx;
  logic            req_ok;
  logic            unused_addr;

  // Contents have no reset; they rely on the memory's power-on zero state.
  logic [LW-1:0]   mem [DEPTH];

  // Word-offset bits are dropped and the index wraps modulo DEPTH.
  assign req_idx     = addr[OFF +: IW];
  assign req_ok      = is_input_valid & (mem_read ^ mem_write);
  assign unused_addr = ^addr;

`ifdef LINE_MEM_BOUNDS_CHECK_EN
  logic req_oob;
  logic err_q, err_d;
  assign req_oob = (addr >> (OFF + IW)) != 32'd0;
  assign err     = err_q;
`endif

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    latch_req = 1'b0;
    mem_we    = 1'b0;
    dout_load = 1'b0;
    valid_d   = 1'b0;
`ifdef LINE_MEM_BOUNDS_CHECK_EN
    err_d     = 1'b0;
`endif
    unique case (state_q)
      StIdle: begin
`ifdef LINE_MEM_BOUNDS_CHECK_EN
        if (req_ok && req_oob) begin
          err_d = 1'b1;
        end else
`endif
        if (req_ok) begin
          latch_req = 1'b1;
          cnt_d     = CW'(LATENCY - 1);
          state_d   = StBusy;
        end
      end
      StBusy: begin
        if (cnt_q == '0) begin
          if (write_q) begin
            mem_we  = ~reset;
            state_d = StIdle;
          end else begin
            dout_load = 1'b1;
            valid_d   = 1'b1;
            state_d   = StResp;
          end
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      StResp: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      valid_q <= 1'b0;
      dout_q  <= '0;
`ifdef LINE_MEM_BOUNDS_CHECK_EN
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
      if (dout_load) begin
        dout_q <= mem[idx_q];
      end
`ifdef LINE_MEM_BOUNDS_CHECK_EN
      err_q   <= err_d;
`endif
    end
  end

  // Request registers only load on acceptance; inputs while busy are ignored.
  always_ff @(posedge clk) begin
    if (latch_req && !reset) begin
      idx_q   <= req_idx;
      write_q <= mem_write;
      din_q   <= din;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[idx_q] <= din_q;
    end
  end

  assign is_output_valid = valid_q;
  assign dout            = dout_q;
  assign mem_ready       = (state_q == StIdle);

endmodule

// File: tb/tb_line_mem.sv
// Self-checking bench for line_mem (LINE_SIZE=16, DEPTH=16, LATENCY=3) against a
// transaction-level reference model; honours LINE_MEM_BOUNDS_CHECK_EN when defined.
module tb_line_mem;

  localparam int unsigned LS  = 16;
  localparam int unsigned DEP = 16;
  localparam int unsigned LAT = 3;
  localparam int unsigned LW  = LS * 8;

  logic          clk = 1'b0;
  logic          reset;
  logic          is_input_valid;
  logic [31:0]   addr;
  logic          mem_read;
  logic          mem_write;
  logic [LW-1:0] din;
  logic          is_output_valid;
  logic [LW-1:0] dout;
  logic          mem_ready;
`ifdef LINE_MEM_BOUNDS_CHECK_EN
  logic          err;
`endif

  line_mem #(
    .LINE_SIZE(LS),
    .DEPTH    (DEP),
    .LATENCY  (LAT)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .is_input_valid (is_input_valid),
    .addr           (addr),
    .mem_read       (mem_read),
    .mem_write      (mem_write),
    .din            (din),
    .is_output_valid(is_output_valid),
    .dout           (dout),
    .mem_ready      (mem_ready)
`ifdef LINE_MEM_BOUNDS_CHECK_EN
    ,
    .err            (err)
`endif
  );

  always #5 clk = ~clk;

  int            n_cmp  = 0;
  int            n_fail = 0;
  logic [LW-1:0] model_mem [DEP];
  logic [LW-1:0] last_dout;

  task automatic check(input string tag, input logic [LW-1:0] obs, input logic [LW-1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [LW-1:0] rnd_line();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  function automatic int line_of(input logic [31:0] a);
    return int'((a >> 2) % DEP);
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_idle();
    is_input_valid = 1'b0;
    mem_read       = 1'b0;
    mem_write      = 1'b0;
  endtask

  // One full transaction; while it is in flight, competing requests are driven and must
  // be ignored. Ends in the first IDLE cycle so the next call is back-to-back.
  task automatic xact(input bit wr, input logic [31:0] a, input logic [LW-1:0] d);
    int t;
    int idx;
    t   = wr ? LAT : LAT + 1;
    idx = line_of(a);
    check("ready_before_req", mem_ready, 1'b1);
    is_input_valid = 1'b1;
    mem_read       = !wr;
    mem_write      = wr;
    addr           = a;
    din            = d;
    step();
    if (wr) model_mem[idx] = d;
    for (int e = 0; e <= t; e++) begin
      if (!wr && e == LAT) last_dout = model_mem[idx];
      check(wr ? "wr_ready" : "rd_ready", mem_ready, (e == t));
      check(wr ? "wr_valid" : "rd_valid", is_output_valid, (!wr && e == LAT));
      check(wr ? "wr_dout_hold" : "rd_dout", dout, last_dout);
      if (e < t) begin
        is_input_valid = 1'b1;
        mem_write      = $urandom_range(0, 1) == 1;
        mem_read       = !mem_write;
        addr           = $urandom;
        din            = rnd_line();
        step();
      end else begin
        drive_idle();
      end
    end
  endtask

  initial begin
    for (int i = 0; i < DEP; i++) model_mem[i] = '0;
    last_dout = '0;
    reset     = 1'b1;
    addr      = '0;
    din       = '0;
    drive_idle();
    step();
    step();
    check("reset_ready", mem_ready, 1'b1);
    check("reset_valid", is_output_valid, 1'b0);
    check("reset_dout", dout, '0);
    reset = 1'b0;
    step();

    // Write then read the same line through a different word offset.
    xact(1'b1, 32'h14, {8{16'hAAAA}});
    xact(1'b0, 32'h17, '0);
    // Unwritten line reads as zero.
    xact(1'b0, 32'h08, '0);

    // Both ops, then neither op: never accepted.
    is_input_valid = 1'b1;
    mem_read       = 1'b1;
    mem_write      = 1'b1;
    addr           = 32'h0C;
    din            = rnd_line();
    for (int i = 0; i < 4; i++) begin
      if (i == 2) begin
        mem_read  = 1'b0;
        mem_write = 1'b0;
      end
      step();
      check("bad_op_ready", mem_ready, 1'b1);
      check("bad_op_valid", is_output_valid, 1'b0);
    end
    drive_idle();
    step();

    // Write to line 1 with competing requests (including to line 0), then line 0 stays 0.
    xact(1'b1, 32'h04, rnd_line());
    xact(1'b0, 32'h00, '0);
    xact(1'b0, 32'h04, '0);

    // Reset on the second BUSY cycle of a write aborts it.
    check("abort_ready_pre", mem_ready, 1'b1);
    is_input_valid = 1'b1;
    mem_write      = 1'b1;
    addr           = 32'h10;
    din            = rnd_line();
    step();
    drive_idle();
    step();
    check("abort_busy", mem_ready, 1'b0);
    reset = 1'b1;
    step();
    reset     = 1'b0;
    last_dout = '0;
    check("abort_ready", mem_ready, 1'b1);
    check("abort_dout", dout, '0);
    for (int i = 0; i < 4; i++) begin
      step();
      check("abort_quiet_ready", mem_ready, 1'b1);
      check("abort_quiet_valid", is_output_valid, 1'b0);
    end
    xact(1'b0, 32'h10, '0);

    // Index 16 is out of range for DEPTH=16.
`ifdef LINE_MEM_BOUNDS_CHECK_EN
    is_input_valid = 1'b1;
    mem_write      = 1'b1;
    addr           = 32'h40;
    din            = rnd_line();
    step();
    drive_idle();
    check("oob_err", err, 1'b1);
    check("oob_ready", mem_ready, 1'b1);
    step();
    check("oob_err_pulse", err, 1'b0);
    check("oob_no_busy", mem_ready, 1'b1);
    xact(1'b0, 32'h00, '0);
`else
    xact(1'b1, 32'h40, rnd_line());
    xact(1'b0, 32'h00, '0);
`endif

    // Randomized back-to-back traffic.
    for (int n = 0; n < 60; n++) begin
      logic [31:0] a;
`ifdef LINE_MEM_BOUNDS_CHECK_EN
      a = $urandom & 32'h3F;
`else
      a = $urandom;
`endif
      xact($urandom_range(0, 1) == 1, a, rnd_line());
    end
    for (int i = 0; i < DEP; i++) xact(1'b0, 32'(i * 4), '0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
